// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg : parametrised UART receiver
//
// Receives LSB-first asynchronous serial frames on RX. A frame is one start
// bit, DATA_BITS data bits, an optional parity bit and one stop bit. Each bit
// lasts BAUD_DIV clk cycles. The receiver synchronises RX, rejects false
// starts, and flags framing errors, parity errors and overrun.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a parity bit follows the data and is checked
//               (PARITY_ODD = 0 selects even parity, 1 selects odd parity).
//   undefined : the stop bit follows the data directly and parity_err is 0.
//
// Parameters
//   DATA_BITS  : data bits per frame, 5..9
//   BAUD_DIV   : clk cycles per bit, >= 8
//   PARITY_ODD : parity sense, used only with UART_RX_PARITY_EN
//
// Ports
//   clk        in  : system clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   RX         in  : serial input, asynchronous, idle high
//   clr_rdy    in  : consumer acknowledge; clears rdy and all flags
//   rx_data    out : last received data word
//   rdy        out : frame complete, rx_data valid
//   frame_err  out : stop bit of the last frame sampled 0
//   parity_err out : parity mismatch on the last frame
//   overrun    out : a frame completed while rdy was still set (sticky)
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 43,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    // DONE is the single cycle between the stop sample and the output load;
    // it also watches for the next start bit so back-to-back frames keep
    // their timing.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam logic ODD_BIT = (PARITY_ODD != 32'sd0);

    // Returns 1 when data plus parity bit do not match the selected sense.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                        input logic                 pbit);
        parity_bad = (^data) ^ pbit ^ ODD_BIT;
    endfunction

    logic pbit_q, pbit_d;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = (PARITY_ODD != 32'sd0);
`endif

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   stop_q, stop_d;
    logic                   armed_q, armed_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rdy_q, rdy_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_s;

    assign rx_s       = sync2_q;
    assign rx_data    = rx_data_q;
    assign rdy        = rdy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    // Next-state, datapath and flag logic for the receive state machine.
    always_comb begin
        sync1_d      = RX;
        sync2_d      = sync1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        stop_d       = stop_q;
        armed_d      = armed_q;
        rx_data_d    = rx_data_q;
        rdy_d        = rdy_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
`ifdef UART_RX_PARITY_EN
        pbit_d       = pbit_q;
`endif

        // Acknowledge clears everything; a completing frame below overrides.
        if (clr_rdy) begin
            rdy_d        = 1'b0;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            rdy_d        = rdy_q;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                bit_d = BIT_ZERO;
                if (armed_q) begin
                    if (!rx_s) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // After a framing error wait for the line to go high
                    // so a held break is not taken as a new start bit.
                    armed_d = rx_s;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = CNT_ZERO;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = CNT_ZERO;
                    pbit_d  = rx_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = CNT_ZERO;
                    stop_d  = rx_s;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                rx_data_d   = shift_q;
                rdy_d       = 1'b1;
                frame_err_d = !stop_q;
`ifdef UART_RX_PARITY_EN
                parity_err_d = parity_bad(shift_q, pbit_q);
`else
                parity_err_d = 1'b0;
`endif
                if (clr_rdy) begin
                    overrun_d = 1'b0;
                end else begin
                    overrun_d = overrun_q | rdy_q;
                end
                armed_d = stop_q;
                cnt_d   = CNT_ZERO;
                if (stop_q && !rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                bit_d   = BIT_ZERO;
            end
        endcase
    end

    // Register bank; reset leaves the receiver idle, armed, line seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            bit_q        <= BIT_ZERO;
            shift_q      <= {DATA_BITS{1'b0}};
            stop_q       <= 1'b1;
            armed_q      <= 1'b1;
            rx_data_q    <= {DATA_BITS{1'b0}};
            rdy_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= 1'b0;
`endif
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            stop_q       <= stop_d;
            armed_q      <= armed_d;
            rx_data_q    <= rx_data_d;
            rdy_q        <= rdy_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= pbit_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg : directed self-checking bench for uart_rx_cfg
//
// Default build: 8 data bits, 43 clk per bit, no parity. Covers reset
// values, frame latency, false start, break/framing error with re-arming,
// back-to-back overrun, acknowledge coinciding with completion and reset
// in the middle of a frame.
// With UART_RX_PARITY_EN: 7 data bits, even parity, parity checks plus the
// reset-mid-frame sequence.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

`ifdef UART_RX_PARITY_EN
    localparam int DB = 7;
    localparam int PB = 1;
`else
    localparam int DB = 8;
    localparam int PB = 0;
`endif
    localparam int BD = 43;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          RX;
    logic          clr_rdy;
    logic [DB-1:0] rx_data;
    logic          rdy;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   rise_cyc  = 0;
    int   start_cyc = 0;
    logic rdy_prev  = 1'b0;

    uart_rx_cfg #(
        .DATA_BITS (DB),
        .BAUD_DIV  (BD),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .clr_rdy   (clr_rdy),
        .rx_data   (rx_data),
        .rdy       (rdy),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Cycle counter, one step per rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Remember the cycle at which rdy last rose.
    always @(negedge clk) begin
        if (rdy && !rdy_prev) rise_cyc <= cyc;
        rdy_prev <= rdy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start bit, data LSB first, optional parity, stop bit held stop_len clk.
    task automatic send_frame(input logic [8:0] d, input logic p, input logic s,
                              input int stop_len);
        start_cyc = cyc;
        RX = 1'b0;
        repeat (BD) @(posedge clk);
        #1;
        for (int i = 0; i < DB; i++) begin
            RX = d[i];
            repeat (BD) @(posedge clk);
            #1;
        end
        if (PB == 1) begin
            RX = p;
            repeat (BD) @(posedge clk);
            #1;
        end
        RX = s;
        repeat (stop_len) @(posedge clk);
        #1;
        RX = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        RX      = 1'b1;
        clr_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rdy", 32'(rdy), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_parity_err", 32'(parity_err), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        pulse_clr();
        repeat (5) @(posedge clk);
        #1;

`ifdef UART_RX_PARITY_EN
        // 0x35 has four ones: even parity bit 0 is correct, 1 is wrong.
        send_frame(9'h035, 1'b0, 1'b1, BD);
        chk("par_ok_data", 32'(rx_data), 32'h35);
        chk("par_ok_rdy", 32'(rdy), 32'h1);
        chk("par_ok_perr", 32'(parity_err), 32'h0);
        pulse_clr();
        send_frame(9'h035, 1'b1, 1'b1, BD);
        chk("par_bad_data", 32'(rx_data), 32'h35);
        chk("par_bad_rdy", 32'(rdy), 32'h1);
        chk("par_bad_perr", 32'(parity_err), 32'h1);
        chk("par_bad_ferr", 32'(frame_err), 32'h0);
`else
        // 0x55 frame: rdy rises 3 + 21 + 9*43 + 1 = 412 edges after RX falls.
        send_frame(9'h055, 1'b0, 1'b1, BD);
        chk("f55_data", 32'(rx_data), 32'h55);
        chk("f55_rdy", 32'(rdy), 32'h1);
        chk("f55_ferr", 32'(frame_err), 32'h0);
        chk("f55_perr", 32'(parity_err), 32'h0);
        chk("f55_ovr", 32'(overrun), 32'h0);
        chk("f55_latency", 32'(rise_cyc - start_cyc), 32'd412);
        pulse_clr();
        chk("clr_rdy", 32'(rdy), 32'h0);

        // False start: 15 clk low is gone by the mid-start sample.
        RX = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("fstart_rdy", 32'(rdy), 32'h0);
        send_frame(9'h0A3, 1'b0, 1'b1, BD);
        chk("fa3_data", 32'(rx_data), 32'hA3);
        chk("fa3_rdy", 32'(rdy), 32'h1);
        chk("fa3_ferr", 32'(frame_err), 32'h0);
        pulse_clr();

        // Break: stop bit 0 and the line stays low another 200 clk.
        send_frame(9'h0C6, 1'b0, 1'b0, BD + 200);
        chk("brk_data", 32'(rx_data), 32'hC6);
        chk("brk_ferr", 32'(frame_err), 32'h1);
        chk("brk_rdy", 32'(rdy), 32'h1);
        repeat (300) @(posedge clk);
        #1;
        chk("brk_no_spur_data", 32'(rx_data), 32'hC6);
        chk("brk_no_spur_ovr", 32'(overrun), 32'h0);
        pulse_clr();
        send_frame(9'h012, 1'b0, 1'b1, BD);
        chk("f12_data", 32'(rx_data), 32'h12);
        chk("f12_ferr", 32'(frame_err), 32'h0);
        chk("f12_rdy", 32'(rdy), 32'h1);
        pulse_clr();

        // Back-to-back: next start bit just after the stop midpoint.
        send_frame(9'h011, 1'b0, 1'b1, 24);
        send_frame(9'h022, 1'b0, 1'b1, BD);
        chk("b2b_data", 32'(rx_data), 32'h22);
        chk("b2b_rdy", 32'(rdy), 32'h1);
        chk("b2b_ovr", 32'(overrun), 32'h1);
        chk("b2b_ferr", 32'(frame_err), 32'h0);
        pulse_clr();
        chk("b2b_clr_rdy", 32'(rdy), 32'h0);
        chk("b2b_clr_ovr", 32'(overrun), 32'h0);

        // Acknowledge lands exactly on the stop-sample edge (411 after fall).
        send_frame(9'h05A, 1'b0, 1'b1, BD);
        chk("f5a_rdy", 32'(rdy), 32'h1);
        fork
            send_frame(9'h03C, 1'b0, 1'b1, BD);
            begin
                repeat (410) @(posedge clk);
                #1;
                clr_rdy = 1'b1;
                @(posedge clk);
                #1;
                clr_rdy = 1'b0;
            end
        join
        chk("coinc_data", 32'(rx_data), 32'h3C);
        chk("coinc_rdy", 32'(rdy), 32'h1);
        chk("coinc_ovr", 32'(overrun), 32'h0);
`endif

        // Reset in the middle of a frame while a previous frame is pending.
        fork
            send_frame(9'h041, 1'b0, 1'b1, BD);
            begin
                repeat (200) @(posedge clk);
                #1;
                chk("pre_rst_rdy", 32'(rdy), 32'h1);
                #2;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_rx_data", 32'(rx_data), 32'h0);
                chk("mid_rst_rdy", 32'(rdy), 32'h0);
                chk("mid_rst_ferr", 32'(frame_err), 32'h0);
                chk("mid_rst_perr", 32'(parity_err), 32'h0);
                chk("mid_rst_ovr", 32'(overrun), 32'h0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_frame(9'h041, 1'b0, 1'b1, BD);
        chk("post_rst_data", 32'(rx_data), 32'h41);
        chk("post_rst_rdy", 32'(rdy), 32'h1);
        chk("post_rst_ferr", 32'(frame_err), 32'h0);
        chk("post_rst_ovr", 32'(overrun), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
